// File: rtl/timing_detector.sv
// timing_detector: measures incoming video sync timing, tracks the
// active pixel position and locks once the geometry repeats.
module timing_detector #(
  parameter int busWidth   = 12,
  parameter int lockFrames = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hSyncIn,
  input  logic                vSyncIn,
  input  logic                deIn,
  output logic [busWidth-1:0] hTotal,
  output logic [busWidth-1:0] vTotal,
  output logic [busWidth-1:0] hActive,
  output logic [busWidth-1:0] vActive,
  output logic [busWidth-1:0] xPos,
  output logic [busWidth-1:0] yPos,
  output logic                frameStart,
  output logic                locked
);

  localparam int MW = $clog2(lockFrames + 1);
  localparam logic [busWidth-1:0] MAX = '1;
  localparam logic [MW-1:0] LAST = MW'(lockFrames - 1);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_e;

  function automatic logic [busWidth-1:0] satInc(
    input logic [busWidth-1:0] v
  );
    return (v == MAX) ? v : v + 1'b1;
  endfunction

  state_e state_q;

  logic hs_q, hs_p_q;
  logic vs_q, vs_p_q;
  logic de_q, de_p_q;

  logic [busWidth-1:0] hCount_q, hCount_d;
  logic [busWidth-1:0] vCount_q, vCount_d;
  logic [busWidth-1:0] xPos_q, xPos_d;
  logic [busWidth-1:0] yPos_q, yPos_d;
  logic [busWidth-1:0] hTotal_q, vTotal_q;
  logic [busWidth-1:0] hActive_q, vActive_q;
  logic [MW-1:0]       match_q;
  logic                frameStart_q, locked_q;

  logic                hEdge, vEdge, deFall;
  logic                hMatch, vMatch;
  logic [busWidth-1:0] lineLen, frameLen;

  always_comb begin
    hEdge    = hs_q & ~hs_p_q;
    vEdge    = vs_q & ~vs_p_q;
    deFall   = de_p_q & ~de_q;
    lineLen  = satInc(hCount_q);
    frameLen = satInc(vCount_q);
    hMatch   = (lineLen == hTotal_q);
    vMatch   = (frameLen == vTotal_q);

    hCount_d = hEdge ? '0 : lineLen;

    vCount_d = vCount_q;
    if (vEdge)      vCount_d = '0;
    else if (hEdge) vCount_d = frameLen;

    xPos_d = xPos_q;
    if (hEdge)     xPos_d = '0;
    else if (de_q) xPos_d = satInc(xPos_q);

    yPos_d = yPos_q;
    if (vEdge)       yPos_d = '0;
    else if (deFall) yPos_d = satInc(yPos_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SEARCH;
      hs_q         <= 1'b0;
      hs_p_q       <= 1'b0;
      vs_q         <= 1'b0;
      vs_p_q       <= 1'b0;
      de_q         <= 1'b0;
      de_p_q       <= 1'b0;
      hCount_q     <= '0;
      vCount_q     <= '0;
      xPos_q       <= '0;
      yPos_q       <= '0;
      hTotal_q     <= '0;
      vTotal_q     <= '0;
      hActive_q    <= '0;
      vActive_q    <= '0;
      match_q      <= '0;
      frameStart_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      hs_q         <= hSyncIn;
      hs_p_q       <= hs_q;
      vs_q         <= vSyncIn;
      vs_p_q       <= vs_q;
      de_q         <= deIn;
      de_p_q       <= de_q;
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      xPos_q       <= xPos_d;
      yPos_q       <= yPos_d;
      frameStart_q <= vEdge;

      // measured geometry is frozen while locked
      if (state_q != LOCKED) begin
        if (hEdge)  hTotal_q  <= lineLen;
        if (vEdge)  vTotal_q  <= frameLen;
        if (deFall) hActive_q <= xPos_q;
        if (vEdge)  vActive_q <= yPos_q;
      end

      unique case (state_q)
        SEARCH: begin
          if (vEdge) begin
            state_q <= MEASURE;
            match_q <= '0;
          end
        end
        MEASURE: begin
          if (vEdge) begin
            if (hMatch && vMatch) begin
              match_q <= match_q + 1'b1;
              if (match_q == LAST) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              match_q <= '0;
            end
          end
        end
        LOCKED: begin
          if ((hEdge && !hMatch) ||
              (vEdge && !vMatch) ||
              (hCount_q == MAX)) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign hTotal     = hTotal_q;
  assign vTotal     = vTotal_q;
  assign hActive    = hActive_q;
  assign vActive    = vActive_q;
  assign xPos       = xPos_q;
  assign yPos       = yPos_q;
  assign frameStart = frameStart_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_timing_detector.sv
// tb_timing_detector: scenario tasks plus randomized frames checked
// against a cycle-level model built from counts of elapsed clocks.
module tb_timing_detector;

  localparam int W  = 12;
  localparam int LF = 2;
  localparam int M  = (1 << W) - 1;
  localparam int S_SEARCH  = 0;
  localparam int S_MEASURE = 1;
  localparam int S_LOCKED  = 2;

  logic clock = 1'b0;
  logic reset, hSyncIn, vSyncIn, deIn;
  logic [W-1:0] hTotal, vTotal, hActive, vActive, xPos, yPos;
  logic frameStart, locked;

  int errors = 0;
  int checks = 0;

  timing_detector #(.busWidth(W), .lockFrames(LF)) dut (
    .clock(clock), .reset(reset),
    .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .deIn(deIn),
    .hTotal(hTotal), .vTotal(vTotal),
    .hActive(hActive), .vActive(vActive),
    .xPos(xPos), .yPos(yPos),
    .frameStart(frameStart), .locked(locked)
  );

  always #5 clock = ~clock;

  logic [6*W+1:0] dutv;
  assign dutv = {hTotal, vTotal, hActive, vActive,
                 xPos, yPos, frameStart, locked};

  // model: sampled input history and elapsed-clock counts
  bit h1, h2, v1, v2, d1, d2;
  int sinceH, lines, runX, yCnt;
  int mhT, mvT, mhA, mvA, match, st;
  bit mFs, mLk;

  function automatic int clampv(input int x);
    return (x > M) ? M : x;
  endfunction

  function automatic logic [6*W+1:0] mvec();
    return {W'(mhT), W'(mvT), W'(mhA), W'(mvA),
            W'(clampv(runX)), W'(clampv(yCnt)), mFs, mLk};
  endfunction

  task automatic mstep();
    bit hE, vE, dF, sat;
    int lineLen, frameLen, nst;
    if (reset) begin
      h1 = 0; h2 = 0; v1 = 0; v2 = 0; d1 = 0; d2 = 0;
      sinceH = 0; lines = 0; runX = 0; yCnt = 0;
      mhT = 0; mvT = 0; mhA = 0; mvA = 0;
      match = 0; st = S_SEARCH; mFs = 0; mLk = 0;
      return;
    end
    hE = h1 && !h2;
    vE = v1 && !v2;
    dF = d2 && !d1;
    lineLen  = clampv(sinceH + 1);
    frameLen = clampv(lines + 1);
    sat = (sinceH >= M);
    nst = st;
    if (st == S_SEARCH) begin
      if (vE) begin nst = S_MEASURE; match = 0; end
    end else if (st == S_MEASURE) begin
      if (vE) begin
        if (lineLen == mhT && frameLen == mvT) begin
          match++;
          if (match >= LF) nst = S_LOCKED;
        end else match = 0;
      end
    end else if ((hE && lineLen != mhT) ||
                 (vE && frameLen != mvT) || sat) begin
      nst = S_SEARCH;
    end
    if (st != S_LOCKED) begin
      if (hE) mhT = lineLen;
      if (vE) mvT = frameLen;
      if (dF) mhA = clampv(runX);
      if (vE) mvA = clampv(yCnt);
    end
    st  = nst;
    mLk = (st == S_LOCKED);
    mFs = vE;
    sinceH = hE ? 0 : sinceH + 1;
    if (vE) lines = 0; else if (hE) lines++;
    if (hE) runX = 0; else if (d1) runX++;
    if (vE) yCnt = 0; else if (dF) yCnt++;
    h2 = h1; h1 = hSyncIn;
    v2 = v1; v1 = vSyncIn;
    d2 = d1; d1 = deIn;
  endtask

  task automatic tick(input logic r, input logic h,
                      input logic v, input logic d);
    reset = r; hSyncIn = h; vSyncIn = v; deIn = d;
    @(posedge clock);
    mstep();
    #1;
  endtask

  task automatic drive_line(input int len, input int hw,
                            input int vw, input int ds,
                            input int dl);
    for (int c = 0; c < len; c++)
      tick(1'b0, c < hw, c < vw, c >= ds && c < ds + dl);
  endtask

  // 20-clock line, hsync 2 wide, vsync over line 0, de on lines 2-9
  task automatic std_line(input int n);
    drive_line(20, 2, (n == 0) ? 20 : 0, 4, (n >= 2) ? 12 : 0);
  endtask

  task automatic std_frame();
    for (int n = 0; n < 10; n++) std_line(n);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dutv !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", dutv);
    end
    checks++;
    if (dutv !== mvec()) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", dutv, mvec());
    end
  endtask

  task automatic test_lock();
    for (int n = 1; n < 10; n++) std_line(n);
    std_frame();
    std_line(0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_early: got %b expected 0", locked);
    end
    for (int n = 1; n < 10; n++) std_line(n);
    std_line(0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_locked: got %b expected 1", locked);
    end
    checks++;
    if ({hTotal, vTotal} !== {12'd20, 12'd10}) begin
      errors++;
      $display("FAIL lock_totals: got %0d/%0d expected 20/10",
               hTotal, vTotal);
    end
    checks++;
    if ({hActive, vActive} !== {12'd12, 12'd8}) begin
      errors++;
      $display("FAIL lock_active: got %0d/%0d expected 12/8",
               hActive, vActive);
    end
  endtask

  task automatic test_coincident();
    for (int n = 1; n < 10; n++) std_line(n);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (frameStart !== 1'b0) begin
      errors++;
      $display("FAIL coinc_fs_pre: got %b expected 0", frameStart);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({frameStart, yPos} !== {1'b1, 12'd0}) begin
      errors++;
      $display("FAIL coinc_fs_pulse: got fs=%b y=%0d expected fs=1 y=0",
               frameStart, yPos);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (frameStart !== 1'b0) begin
      errors++;
      $display("FAIL coinc_fs_post: got %b expected 0", frameStart);
    end
    for (int c = 3; c < 20; c++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dutv !== mvec()) begin
      errors++;
      $display("FAIL coinc_model: got %h expected %h", dutv, mvec());
    end
  endtask

  task automatic test_unlock();
    drive_line(19, 2, 0, 0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_hold: got %b expected 1", locked);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL unlock_drop: got %b expected 0", locked);
    end
    for (int c = 2; c < 20; c++)
      tick(1'b0, 1'b0, 1'b0, c >= 4 && c < 16);
    for (int n = 3; n < 10; n++) std_line(n);
    std_frame();
    std_line(0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_early: got %b expected 0", locked);
    end
    for (int n = 1; n < 10; n++) std_line(n);
    std_line(0);
    checks++;
    if ({locked, hTotal} !== {1'b1, 12'd20}) begin
      errors++;
      $display("FAIL relock: got lk=%b h=%0d expected lk=1 h=20",
               locked, hTotal);
    end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 4100; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (k == 4077) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL timeout_hold: got %b expected 1", locked);
        end
      end
      if (k == 4078) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL timeout_drop: got %b expected 0", locked);
        end
      end
    end
    checks++;
    if ({xPos, hTotal, vTotal} !== {12'd4095, 12'd20, 12'd10}) begin
      errors++;
      $display("FAIL timeout_sat: got x=%0d h=%0d v=%0d expected 4095/20/10",
               xPos, hTotal, vTotal);
    end
    checks++;
    if (dutv !== mvec()) begin
      errors++;
      $display("FAIL timeout_model: got %h expected %h", dutv, mvec());
    end
  endtask

  task automatic test_reset_midframe();
    std_frame();
    std_frame();
    for (int n = 0; n < 5; n++) std_line(n);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dutv !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", dutv);
    end
    for (int n = 5; n < 10; n++) begin
      for (int c = 0; c < 20; c++) begin
        tick(1'b0, c < 2, 1'b0, n >= 2 && c >= 4 && c < 16);
        checks++;
        if (frameStart !== 1'b0) begin
          errors++;
          $display("FAIL midreset_fs_idle: got %b expected 0", frameStart);
        end
      end
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({frameStart, locked} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_first_edge: got fs=%b lk=%b expected fs=1 lk=0",
               frameStart, locked);
    end
    for (int c = 2; c < 20; c++) tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int hl, vl, hw, vw, ds, dl, nf, len;
    bit deOn;
    for (int seg = 0; seg < 6; seg++) begin
      hl = $urandom_range(16, 40);
      vl = $urandom_range(4, 12);
      hw = $urandom_range(1, 3);
      vw = $urandom_range(1, hl - 1);
      ds = $urandom_range(hw + 1, hl - 4);
      dl = $urandom_range(1, hl - ds - 1);
      nf = $urandom_range(3, 5);
      for (int f = 0; f < nf; f++) begin
        for (int n = 0; n < vl; n++) begin
          len  = hl + (($urandom_range(0, 24) == 0) ? 1 : 0);
          deOn = (n >= 1) && ($urandom_range(0, 4) != 0);
          for (int c = 0; c < len; c++) begin
            tick(1'b0, c < hw, n == 0 && c < vw,
                 deOn && c >= ds && c < ds + dl);
            checks++;
            if (dutv !== mvec()) begin
              errors++;
              $display("FAIL random_seg%0d: got %h expected %h",
                       seg, dutv, mvec());
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_coincident();
    test_unlock();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timing_detector.md
TIMING_DETECTOR -- requirements
Module: timing_detector

Interface
REQ-001 SHALL have parameter busWidth, default 12, width of all counters and measured values.
REQ-002 SHALL have parameter lockFrames, default 2, number of consecutive matching frames required to enter LOCKED.
REQ-003 SHALL have port clock, input, 1, pixel clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports hSyncIn, vSyncIn and deIn, input, 1 each: incoming horizontal sync, vertical sync and data-enable, all active-high.
REQ-006 SHALL have ports hTotal and vTotal, output, busWidth each: measured clocks per line and lines per frame.
REQ-007 SHALL have ports hActive and vActive, output, busWidth each: measured deIn-high clocks per line and lines containing deIn per frame.
REQ-008 SHALL have ports xPos and yPos, output, busWidth each: active pixel column and active line index.
REQ-009 SHALL have port frameStart, output, 1: single-cycle pulse on each detected vsync edge.
REQ-010 SHALL have port locked, output, 1: high while the timing is stable.

Function
REQ-011 SHALL register hSyncIn, vSyncIn and deIn once; a rising edge is the registered value high while its previous registered value is low.
REQ-012 SHALL set hCount to 0 on an hsync edge and otherwise increment it, saturating at all-ones.
REQ-013 SHALL, on an hsync edge, compute the line length as hCount+1 and load it into hTotal while not LOCKED.
REQ-014 SHALL increment vCount on each hsync edge and clear it on a vsync edge; when both edges occur together, vsync wins and vCount is cleared to 0.
REQ-015 SHALL, on a vsync edge, compute the frame length as vCount+1 and load it into vTotal while not LOCKED.
REQ-016 SHALL increment xPos on each cycle the registered deIn is high, and clear it on an hsync edge.
REQ-017 SHALL, on a registered deIn falling edge, load the xPos run length into hActive while not LOCKED and increment yPos.
REQ-018 SHALL clear yPos on a vsync edge, loading its value into vActive first while not LOCKED.
REQ-019 SHALL raise frameStart for exactly one cycle, in the cycle after the vsync edge is detected (two clocks after vSyncIn is first sampled high).
REQ-020 SHALL implement a state machine with states SEARCH, MEASURE and LOCKED; locked is high only in LOCKED, registered.
REQ-021 SHALL move SEARCH to MEASURE on a vsync edge and clear the match counter.
REQ-022 SHALL, in MEASURE on each vsync edge, increment the match counter if the line and frame lengths equal the stored hTotal/vTotal, else clear it; on reaching lockFrames it SHALL enter LOCKED.
REQ-023 SHALL, in LOCKED, move to SEARCH on any line-length mismatch at an hsync edge, any frame-length mismatch at a vsync edge, or hCount saturation; locked falls the following cycle.
REQ-024 SHALL freeze hTotal, vTotal, hActive and vActive while LOCKED.
REQ-025 SHALL keep xPos and yPos counting in every state.
REQ-026 SHALL saturate every counter at all-ones rather than wrapping.

Reset
REQ-027 SHALL, while reset is high at a clock edge, set the state to SEARCH.
REQ-028 SHALL, on reset, set all outputs to 0 and clear every counter and edge register.
REQ-029 SHALL allow reset mid-frame; the next vsync edge after release is then treated as a first edge.

Verification
REQ-030 SHALL cover lock: a line of 20 clocks (hsync width 2), 10 lines per frame, deIn high 12 clocks on lines 2-9 -> after the third vsync edge locked=1, hTotal=20, vTotal=10, hActive=12, vActive=8.
REQ-031 SHALL cover unlock: once locked, shorten one line to 19 clocks -> locked=0 one cycle after that hsync edge and state SEARCH; relock after lockFrames+1 vsync edges.
REQ-032 SHALL cover coincident edges: hsync and vsync rise on the same clock -> vCount=0, frameStart pulses once, yPos=0.
REQ-033 SHALL cover timeout: hold hSyncIn low for 4096 clocks while locked (busWidth=12) -> hCount saturates at 4095, locked=0, no counter wraps.
REQ-034 SHALL cover reset mid-frame: assert reset at line 5 -> all outputs 0 next cycle, frameStart stays 0 until the next vsync edge.
